button_conditioner: RTL and testbench

Conditions the board's raw active-low push-buttons into clean, glitch-free control signals for the counter/LED stage directly downstream. Each channel runs a 2-flop synchroniser, a per-channel debounce state machine and a long-press detector. Outputs are a debounced pressed level plus single-cycle press, release and hold strobes. btn_level[0] (inverted) drives the counter's active-low reset; the strobes drive step and mode control.

---
 rtl/btn_pkg.sv | 18 +
 rtl/debounce_channel.sv | 126 ++++++++++++
 rtl/button_conditioner.sv | 33 +++
 tb/tb_button_conditioner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning path.
package btn_pkg;

   localparam int unsigned CLK_HZ = 27000000;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Divide first so long durations stay inside 32 bits.
   function automatic int unsigned MS_TO_CYCLES(input int unsigned ms);
      return (CLK_HZ / 1000) * ms;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and long-press detector.
module debounce_channel
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TIME = 270000,
   parameter int unsigned HOLD_TIME     = 27000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_hold
);

   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_TIME);
   localparam int unsigned HOLD_W = $clog2(HOLD_TIME + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TIME - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIME - 1);

   logic sync1, sync2;
   logic pressed_s;

   state_t             state, state_nx;
   logic [DEB_W-1:0]   cnt, cnt_nx;
   logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nx;
   logic               hold_done, hold_done_nx;
   logic               level_nx, press_nx, release_nx, hold_nx;

   // Synchroniser presets to "released" so reset never looks like a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   assign pressed_s = ~sync2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         hold_cnt    <= '0;
         hold_done   <= 1'b0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_hold    <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         hold_cnt    <= hold_cnt_nx;
         hold_done   <= hold_done_nx;
         btn_level   <= level_nx;
         btn_press   <= press_nx;
         btn_release <= release_nx;
         btn_hold    <= hold_nx;
      end
   end

   // Next-state and strobe generation; strobes default low so they last one cycle.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      hold_cnt_nx  = hold_cnt;
      hold_done_nx = hold_done;
      level_nx     = btn_level;
      press_nx     = 1'b0;
      release_nx   = 1'b0;
      hold_nx      = 1'b0;

      unique case (state)
         IDLE: begin
            if (pressed_s) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!pressed_s) begin
               state_nx = IDLE;
            end else if (cnt == DEB_LAST) begin
               state_nx     = PRESSED;
               level_nx     = 1'b1;
               press_nx     = 1'b1;
               hold_cnt_nx  = '0;
               hold_done_nx = 1'b0;
            end else begin
               cnt_nx = cnt + DEB_W'(1);
            end
         end
         PRESSED: begin
            if (!pressed_s) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = '0;
            end else if (!hold_done) begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_nx      = 1'b1;
                  hold_done_nx = 1'b1;
               end else begin
                  hold_cnt_nx = hold_cnt + HOLD_W'(1);
               end
            end
         end
         RELEASE_WAIT: begin
            // A bounce back to pressed resumes the hold timer where it stopped.
            if (pressed_s) begin
               state_nx = PRESSED;
            end else if (cnt == DEB_LAST) begin
               state_nx   = IDLE;
               level_nx   = 1'b0;
               release_nx = 1'b1;
            end else begin
               cnt_nx = cnt + DEB_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw active-low buttons into debounced levels and event strobes.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned NUM_BTN       = 2,
   parameter int unsigned DEBOUNCE_TIME = MS_TO_CYCLES(10),
   parameter int unsigned HOLD_TIME     = MS_TO_CYCLES(1000)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_n,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_hold
);

   for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_TIME (DEBOUNCE_TIME),
         .HOLD_TIME     (HOLD_TIME)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .btn_n       (btn_n[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i]),
         .btn_hold    (btn_hold[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length reference model, segment table and directed corners.
module tb_button_conditioner;

   localparam int NB = 2;
   localparam int DT = 4;
   localparam int HT = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic [NB-1:0] btn_n;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold;

   int errors = 0;
   int checks = 0;

   // Reference model: a change is accepted after DT+1 consecutive synchronised
   // samples that disagree with the current level; hold fires on the HT-th
   // undisturbed pressed sample after the press.
   logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_hold, m_hdone;
   int            m_run  [NB];
   int            m_hcnt [NB];

   typedef struct {
      logic [NB-1:0] btn_n;
      int            cycles;
      int            n_press;
      int            n_rel;
      int            n_hold;
      logic          level_end;
   } seg_t;

   seg_t tbl [16];
   int   rem [NB];

   button_conditioner #(
      .NUM_BTN       (NB),
      .DEBOUNCE_TIME (DT),
      .HOLD_TIME     (HT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_n       (btn_n),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_hold    (btn_hold)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_s1    = '1;
      m_s2    = '1;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_hold  = '0;
      m_hdone = '0;
      for (int i = 0; i < NB; i++) begin
         m_run[i]  = 0;
         m_hcnt[i] = 0;
      end
   endtask

   task automatic model_step();
      logic p;
      if (!reset) begin
         model_reset();
         return;
      end
      m_press = '0;
      m_rel   = '0;
      m_hold  = '0;
      for (int i = 0; i < NB; i++) begin
         p       = ~m_s2[i];
         m_s2[i] = m_s1[i];
         m_s1[i] = btn_n[i];
         if (p != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == DT + 1) begin
               m_level[i] = p;
               m_run[i]   = 0;
               if (p) begin
                  m_press[i] = 1'b1;
                  m_hcnt[i]  = 0;
                  m_hdone[i] = 1'b0;
               end else begin
                  m_rel[i] = 1'b1;
               end
            end
         end else begin
            if (m_level[i] && !m_hdone[i] && m_run[i] == 0) begin
               if (m_hcnt[i] == HT - 1) begin
                  m_hold[i]  = 1'b1;
                  m_hdone[i] = 1'b1;
               end else begin
                  m_hcnt[i]++;
               end
            end
            m_run[i] = 0;
         end
      end
   endtask

   task automatic check2(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string name);
      check2({name, " level"},   btn_level,   '0);
      check2({name, " press"},   btn_press,   '0);
      check2({name, " release"}, btn_release, '0);
      check2({name, " hold"},    btn_hold,    '0);
   endtask

   // One clock: advance the model on the edge, compare just after it.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check2("model level",   btn_level,   m_level);
      check2("model press",   btn_press,   m_press);
      check2("model release", btn_release, m_rel);
      check2("model hold",    btn_hold,    m_hold);
   endtask

   initial begin
      int np, nr, nh;

      tbl[0] = '{2'b11, 10, 0, 1, 0, 1'b0};
      for (int s = 0; s < 5; s++) begin
         tbl[1 + 2*s] = '{2'b10, 3, 0, 0, 0, 1'b0};
         tbl[2 + 2*s] = '{2'b11, 3, 0, 0, 0, 1'b0};
      end
      tbl[11] = '{2'b10,  8, 1, 0, 0, 1'b1};
      tbl[12] = '{2'b10, 50, 0, 0, 1, 1'b1};
      tbl[13] = '{2'b11,  2, 0, 0, 0, 1'b1};
      tbl[14] = '{2'b10,  2, 0, 0, 0, 1'b1};
      tbl[15] = '{2'b11, 10, 0, 1, 0, 1'b0};

      // Reset held with both buttons pressed
      reset = 1'b0;
      btn_n = 2'b00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b1;
      btn_n = 2'b11;
      repeat (20) tick();
      check2("idle level", btn_level, 2'b00);

      // Clean press on channel 0: press at edge 6, hold 10 cycles later
      btn_n = 2'b10;
      for (int k = 0; k < 30; k++) begin
         tick();
         check2("t2 press", btn_press, (k == 6)  ? 2'b01 : 2'b00);
         check2("t2 level", btn_level, (k >= 6)  ? 2'b01 : 2'b00);
         check2("t2 hold",  btn_hold,  (k == 16) ? 2'b01 : 2'b00);
      end

      // Segment table: release, bounces, press, hold, glitchy release
      for (int s = 0; s < 16; s++) begin
         btn_n = tbl[s].btn_n;
         np = 0;
         nr = 0;
         nh = 0;
         for (int c = 0; c < tbl[s].cycles; c++) begin
            tick();
            np += int'(btn_press[0]);
            nr += int'(btn_release[0]);
            nh += int'(btn_hold[0]);
         end
         check_int($sformatf("seg%0d press", s),   np, tbl[s].n_press);
         check_int($sformatf("seg%0d release", s), nr, tbl[s].n_rel);
         check_int($sformatf("seg%0d hold", s),    nh, tbl[s].n_hold);
         check_int($sformatf("seg%0d level", s),   int'(btn_level[0]), int'(tbl[s].level_end));
      end

      // Both buttons pressed in the same cycle
      btn_n = 2'b00;
      for (int k = 0; k < 10; k++) begin
         tick();
         check2("both press", btn_press, (k == 6) ? 2'b11 : 2'b00);
         check2("both level", btn_level, (k >= 6) ? 2'b11 : 2'b00);
      end

      // Reset while channel 0 sits in PRESS_WAIT and channel 1 is pressed
      btn_n = 2'b01;
      repeat (10) tick();
      check2("pre-reset level", btn_level, 2'b10);
      btn_n = 2'b00;
      repeat (5) tick();
      reset = 1'b0;
      #1;
      model_reset();
      check_zero("mid reset");
      repeat (2) tick();
      reset = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check2("post-reset press", btn_press, (k == 6) ? 2'b11 : 2'b00);
      end

      // Random bouncing on both channels with occasional resets
      for (int i = 0; i < NB; i++) rem[i] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NB; i++) begin
            if (rem[i] == 0) begin
               btn_n[i] = 1'($urandom_range(0, 1));
               rem[i]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 25))
                                                      : int'($urandom_range(1, 6));
            end
            rem[i]--;
         end
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b0;
            #1;
            model_reset();
            check_zero("rand reset");
            tick();
            reset = 1'b1;
         end else begin
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
